// File: rtl/ifetch.sv
// Instruction fetch sequencer: reads a 32-bit instruction as two 16-bit beats and
// steps the decoder/datapath through DEC, EXEC and WB with a one-hot stage vector.
module ifetch #(
    parameter int unsigned AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   pc,
    input  logic          stall,
    input  logic          halt,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [15:0]   imem_rdata,
    output logic [31:0]   inst,
    output logic [15:0]   inst_pc,
    output logic [3:0]    stage
);

    typedef enum logic [3:0] {
        StIdle,
        StReqLo,
        StWaitLo,
        StReqHi,
        StWaitHi,
        StDec,
        StExec,
        StWb,
        StHalt
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   fpc_q, fpc_d;
    logic [15:0]   shadow_lo_q, shadow_lo_d;
    logic [31:0]   inst_q, inst_d;
    logic [15:0]   inst_pc_q, inst_pc_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    stage_q, stage_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   state_d = StReqLo;
            StReqLo:  if (imem_gnt) state_d = StWaitLo;
            StWaitLo: if (imem_rvalid) state_d = StReqHi;
            StReqHi:  if (imem_gnt) state_d = StWaitHi;
            StWaitHi: if (imem_rvalid) state_d = StDec;
            StDec:    state_d = StExec;
            StExec:   if (!stall) state_d = StWb;
            StWb:     state_d = halt ? StHalt : StReqLo;
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        fpc_d       = fpc_q;
        shadow_lo_d = shadow_lo_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        addr_d      = addr_q;

        if (state_d == StReqLo && state_q != StReqLo) begin
            fpc_d = pc;
        end
        if (state_q == StWaitLo && imem_rvalid) begin
            shadow_lo_d = imem_rdata;
        end
        if (state_q == StWaitHi && imem_rvalid) begin
            inst_d    = {imem_rdata, shadow_lo_q};
            inst_pc_d = fpc_q;
        end

        req_d = (state_d == StReqLo) || (state_d == StReqHi);
        if (state_d == StReqLo) begin
            addr_d = {fpc_d[AW-2:0], 1'b0};
        end else if (state_d == StReqHi) begin
            addr_d = {fpc_d[AW-2:0], 1'b1};
        end

        stage_d = 4'b0000;
        unique case (state_d)
            StReqLo, StWaitLo, StReqHi, StWaitHi: stage_d = 4'b0001;
            StDec:                                stage_d = 4'b0010;
            StExec:                               stage_d = 4'b0100;
            StWb:                                 stage_d = 4'b1000;
            default:                              stage_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            fpc_q       <= '0;
            shadow_lo_q <= '0;
            inst_q      <= '0;
            inst_pc_q   <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            stage_q     <= 4'b0000;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            shadow_lo_q <= shadow_lo_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            stage_q     <= stage_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign inst      = inst_q;
    assign inst_pc   = inst_pc_q;
    assign stage     = stage_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a small handshaking instruction memory model.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic        stall;
    logic        halt;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic [31:0] inst;
    logic [15:0] inst_pc;
    logic [3:0]  stage;

    int errors = 0;
    int checks = 0;

    // Memory model controls and observations
    logic [15:0] mem [logic [15:0]];
    int          gnt_delay;
    int          rv_delay;
    logic        spur;
    logic        watch;
    logic [31:0] inst_ref;
    int          inst_changed;
    int          stable_err;
    logic [15:0] addr_log [$];

    ifetch #(.AW(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .stall       (stall),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .stage       (stage)
    );

    always #5 clk = ~clk;

    // Memory responder: grant after gnt_delay waiting cycles, data rv_delay cycles after grant.
    initial begin
        logic        pend;
        logic        waiting;
        logic [15:0] paddr;
        logic [15:0] last_addr;
        int          wcnt;
        int          rcnt;
        pend = 1'b0; waiting = 1'b0; wcnt = 0; rcnt = 0;
        paddr = '0; last_addr = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            if (watch && stage == 4'b0001 && inst !== inst_ref) inst_changed++;
            if (rst) begin
                pend = 1'b0; waiting = 1'b0; wcnt = 0;
            end else if (spur) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 16'hDEAD;
                spur        = 1'b0;
            end else if (pend) begin
                rcnt++;
                if (rcnt >= rv_delay) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem[paddr];
                    pend        = 1'b0;
                end
            end else if (imem_req) begin
                if (waiting && imem_addr !== last_addr) stable_err++;
                last_addr = imem_addr;
                if (wcnt >= gnt_delay) begin
                    imem_gnt = 1'b1;
                    paddr    = imem_addr;
                    addr_log.push_back(imem_addr);
                    pend     = 1'b1;
                    rcnt     = 0;
                    wcnt     = 0;
                    waiting  = 1'b0;
                end else begin
                    wcnt++;
                    waiting = 1'b1;
                end
            end else if (waiting) begin
                stable_err++;
                waiting = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Counts cycles spent in stage s, bounded so a stuck DUT cannot hang the run.
    task automatic count_stage(input logic [3:0] s, output int n);
        n = 0;
        while (stage === s && n < 64) begin
            tick(1);
            n++;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; pc = 16'h0003; stall = 1'b0; halt = 1'b0;
        gnt_delay = 0; rv_delay = 1; spur = 1'b0; watch = 1'b0;
        inst_ref = '0; inst_changed = 0; stable_err = 0;
        mem[16'h0006] = 16'h1234;
        mem[16'h0007] = 16'hABCD;

        // Reset state and the single IDLE cycle
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_stage", 32'(stage), 32'h0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", 32'(imem_addr), 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", 32'(inst_pc), 32'h0);

        // Basic fetch
        tick(1);
        chk("t1_req", 32'(imem_req), 32'h1);
        chk("t1_addr_lo", 32'(imem_addr), 32'h0006);
        chk("t1_stage_f", 32'(stage), 32'h1);
        count_stage(4'b0001, n);
        chk("t1_fetch_len", n, 4);
        chk("t1_stage_dec", 32'(stage), 32'h2);
        chk("t1_inst", inst, 32'hABCD1234);
        chk("t1_inst_pc", 32'(inst_pc), 32'h0003);
        chk("t1_log0", 32'(addr_log[0]), 32'h0006);
        chk("t1_log1", 32'(addr_log[1]), 32'h0007);
        tick(1);
        chk("t1_stage_exec", 32'(stage), 32'h4);
        tick(1);
        chk("t1_stage_wb", 32'(stage), 32'h8);
        tick(1);
        chk("t1_period", 32'(stage), 32'h1);

        // Grant and data wait
        gnt_delay = 2; rv_delay = 2;
        mem[16'h0006] = 16'h1111;
        mem[16'h0007] = 16'h2222;
        inst_ref = 32'hABCD1234; inst_changed = 0; stable_err = 0; watch = 1'b1;
        addr_log.delete();
        count_stage(4'b0001, n);
        watch = 1'b0;
        chk("t2_fetch_len", n, 10);
        chk("t2_stable", stable_err, 0);
        chk("t2_inst_held", inst_changed, 0);
        chk("t2_inst", inst, 32'h22221111);
        chk("t2_inst_pc", 32'(inst_pc), 32'h0003);
        chk("t2_log1", 32'(addr_log[1]), 32'h0007);

        // Stall in EXEC and pc change during fetch
        gnt_delay = 0; rv_delay = 1;
        stall = 1'b1;
        tick(1);
        tick(5);
        chk("t3_exec_stall", 32'(stage), 32'h4);
        pc = 16'h0020;
        mem[16'h0040] = 16'h0F0F;
        mem[16'h0041] = 16'hF0F0;
        stall = 1'b0;
        tick(1);
        chk("t3_stage_wb", 32'(stage), 32'h8);
        tick(1);
        chk("t3_addr_lo", 32'(imem_addr), 32'h0040);
        pc = 16'h0099;
        addr_log.delete();
        count_stage(4'b0001, n);
        chk("t3_fetch_len", n, 4);
        chk("t3_inst", inst, 32'hF0F00F0F);
        chk("t3_inst_pc", 32'(inst_pc), 32'h0020);
        chk("t3_log1", 32'(addr_log[1]), 32'h0041);

        // Halt with stall: stall wins, then WB, then HALT
        halt = 1'b1; stall = 1'b1;
        tick(1);
        tick(2);
        chk("t4_stall_wins", 32'(stage), 32'h4);
        stall = 1'b0;
        tick(1);
        chk("t4_stage_wb", 32'(stage), 32'h8);
        tick(1);
        chk("t4_halt_stage", 32'(stage), 32'h0);
        chk("t4_halt_req", 32'(imem_req), 32'h0);
        halt = 1'b0;
        tick(5);
        chk("t4_stay_stage", 32'(stage), 32'h0);
        chk("t4_stay_req", 32'(imem_req), 32'h0);
        chk("t4_stay_inst", inst, 32'hF0F00F0F);

        // Reset from HALT, then reset mid WAIT_HI, refetch, spurious rvalid
        pc = 16'h0003;
        mem[16'h0006] = 16'h1234;
        mem[16'h0007] = 16'hABCD;
        rv_delay = 3;
        rst = 1'b1;
        tick(1);
        chk("t5_rst_inst", inst, 32'h0);
        chk("t5_rst_inst_pc", 32'(inst_pc), 32'h0);
        chk("t5_rst_stage", 32'(stage), 32'h0);
        rst = 1'b0;
        tick(1);
        chk("t5_req", 32'(imem_req), 32'h1);
        tick(5);
        chk("t5_wait_hi_stage", 32'(stage), 32'h1);
        chk("t5_wait_hi_req", 32'(imem_req), 32'h0);
        rst = 1'b1;
        tick(1);
        chk("t5_mid_stage", 32'(stage), 32'h0);
        chk("t5_mid_req", 32'(imem_req), 32'h0);
        chk("t5_mid_addr", 32'(imem_addr), 32'h0);
        rst = 1'b0;
        chk("t5_idle_req", 32'(imem_req), 32'h0);
        rv_delay = 1;
        addr_log.delete();
        tick(1);
        chk("t5_refetch_req", 32'(imem_req), 32'h1);
        chk("t5_refetch_addr", 32'(imem_addr), 32'h0006);
        count_stage(4'b0001, n);
        chk("t5_fetch_len", n, 4);
        chk("t5_inst", inst, 32'hABCD1234);
        spur = 1'b1;
        tick(1);
        chk("t5_spur_stage", 32'(stage), 32'h4);
        chk("t5_spur_inst", inst, 32'hABCD1234);

        // Address wrap
        pc = 16'hFFFF;
        mem[16'hFFFE] = 16'h5555;
        mem[16'hFFFF] = 16'hAAAA;
        tick(1);
        tick(1);
        chk("t6_addr_lo", 32'(imem_addr), 32'hFFFE);
        addr_log.delete();
        count_stage(4'b0001, n);
        chk("t6_fetch_len", n, 4);
        chk("t6_log1", 32'(addr_log[1]), 32'hFFFF);
        chk("t6_inst", inst, 32'hAAAA5555);
        chk("t6_inst_pc", 32'(inst_pc), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
